// File: rtl/seq_detect_pkg.sv
// Shared types and constant-evaluable helpers for the serial pattern detector.
// The border functions build the FSM transition table at elaboration time.
package seq_detect_pkg;

  typedef enum logic {
    MODE_RESTART = 1'b0,
    MODE_OVERLAP = 1'b1
  } mode_e;

  localparam int MAX_LEN = 16;

  function automatic int st_width(input int len);
    return (len <= 2) ? 1 : $clog2(len);
  endfunction

  // Largest j < k such that the j-bit suffix of the k-bit pattern prefix equals its j-bit prefix.
  function automatic int prefix_suffix(input logic [MAX_LEN-1:0] pattern, input int len,
                                       input int k);
    int best;
    bit ok;
    best = 0;
    for (int j = 1; j < MAX_LEN; j++) begin
      if (j < k) begin
        ok = 1'b1;
        for (int i = 0; i < MAX_LEN; i++) begin
          if (i < j && pattern[len-1-(k-j+i)] != pattern[len-1-i]) ok = 1'b0;
        end
        if (ok) best = j;
      end
    end
    return best;
  endfunction

  // Matched length after appending bit d to a state holding s matched bits (may equal len).
  function automatic int next_len(input logic [MAX_LEN-1:0] pattern, input int len,
                                  input int s, input logic d);
    int j;
    int res;
    bit done;
    j = s;
    res = 0;
    done = 1'b0;
    for (int it = 0; it <= MAX_LEN; it++) begin
      if (!done) begin
        if (pattern[len-1-j] == d) begin
          res = j + 1;
          done = 1'b1;
        end else if (j == 0) begin
          res = 0;
          done = 1'b1;
        end else begin
          j = prefix_suffix(pattern, len, j);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_detect_fsm_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc && (value != '1)) begin
      value <= value + W'(1);
    end
  end

endmodule

// File: rtl/seq_detect_fsm.sv
// Parametrised serial pattern detector with overlap/restart mode and saturating match count.
// Transitions are precomputed per state so the runtime logic is a small table lookup.
module seq_detect_fsm
  import seq_detect_pkg::*;
#(
  parameter int             LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b1011,
  parameter int             CNT_W   = 8,
  parameter int             ST_W    = st_width(LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic             overlap,
  input  logic             clr,
  output logic [ST_W-1:0]  state,
  output logic             match,
  output logic [CNT_W-1:0] count
);

  localparam logic [MAX_LEN-1:0] PAT_EXT = MAX_LEN'(PATTERN);
  localparam int                 F       = prefix_suffix(PAT_EXT, LEN, LEN);

  logic [ST_W-1:0] nxt0 [LEN];
  logic [ST_W-1:0] nxt1 [LEN];
  logic [LEN-1:0]  hit0;
  logic [LEN-1:0]  hit1;

  logic [ST_W-1:0] state_next;
  logic [ST_W-1:0] adv;
  logic            hit;
  logic            match_next;
  logic            inc;
  mode_e           mode;

  // One table entry per state: a full-length result flags a match instead of a state.
  for (genvar k = 0; k < LEN; k++) begin : g_tab
    localparam int T0 = next_len(PAT_EXT, LEN, k, 1'b0);
    localparam int T1 = next_len(PAT_EXT, LEN, k, 1'b1);
    assign nxt0[k] = (T0 == LEN) ? '0 : ST_W'(T0);
    assign nxt1[k] = (T1 == LEN) ? '0 : ST_W'(T1);
    assign hit0[k] = (T0 == LEN);
    assign hit1[k] = (T1 == LEN);
  end

  assign mode = mode_e'(overlap);

  always_comb begin
    state_next = state;
    match_next = 1'b0;
    inc        = 1'b0;
    hit        = din ? hit1[state] : hit0[state];
    adv        = din ? nxt1[state] : nxt0[state];
    if (clr) begin
      state_next = '0;
    end else if (en) begin
      if (hit) begin
        match_next = 1'b1;
        inc        = 1'b1;
        state_next = (mode == MODE_OVERLAP) ? ST_W'(F) : '0;
      end else begin
        state_next = adv;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= '0;
      match <= 1'b0;
    end else begin
      state <= state_next;
      match <= match_next;
    end
  end

  sat_counter #(.W(CNT_W)) u_count (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .inc   (inc),
    .value (count)
  );

  assert property (@(posedge clk) disable iff (rst) int'(state) < LEN);

endmodule

// File: tb/tb_seq_detect_fsm.sv
// Directed bench for seq_detect_fsm (PATTERN=1011); a second instance with CNT_W=2 covers saturation.
module tb_seq_detect_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       din;
  logic       overlap;
  logic       clr;
  logic [1:0] state;
  logic       match;
  logic [7:0] count;
  logic [1:0] sat_state;
  logic       sat_match;
  logic [1:0] sat_count;

  int total = 0;
  int bad   = 0;

  int exp_ovl_st[7]  = '{1, 2, 3, 1, 2, 3, 1};
  int exp_ovl_m[7]   = '{0, 0, 0, 1, 0, 0, 1};
  int exp_rst_st[7]  = '{1, 2, 3, 0, 0, 1, 1};
  int exp_rst_m[7]   = '{0, 0, 0, 1, 0, 0, 0};
  int gap_en[7]      = '{1, 1, 0, 0, 0, 1, 1};
  int gap_din[7]     = '{1, 0, 1, 1, 0, 1, 1};
  int gap_st[7]      = '{1, 2, 2, 2, 2, 3, 0};
  int gap_m[7]       = '{0, 0, 0, 0, 0, 0, 1};

  always #5 clk = ~clk;

  seq_detect_fsm dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .din     (din),
    .overlap (overlap),
    .clr     (clr),
    .state   (state),
    .match   (match),
    .count   (count)
  );

  seq_detect_fsm #(.CNT_W(2)) dut_sat (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .din     (din),
    .overlap (overlap),
    .clr     (clr),
    .state   (sat_state),
    .match   (sat_match),
    .count   (sat_count)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive on the falling edge, return just after the following rising edge.
  task automatic applyStimulus(input logic e, input logic d, input logic c);
    @(negedge clk);
    en  = e;
    din = d;
    clr = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [6:0]  stream7;
    logic [15:0] stream16;
    int          n_match;
    int          exp_m;

    rst = 1'b1; en = 1'b0; din = 1'b0; overlap = 1'b1; clr = 1'b0;
    #12;
    checkOutput("reset state", int'(state), 0);
    checkOutput("reset match", int'(match), 0);
    checkOutput("reset count", int'(count), 0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] overlapping detection");
    stream7 = 7'b1011011;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, stream7[6-i], 1'b0);
      checkOutput($sformatf("ovl state[%0d]", i), int'(state), exp_ovl_st[i]);
      checkOutput($sformatf("ovl match[%0d]", i), int'(match), exp_ovl_m[i]);
      if (i == 3) checkOutput("ovl count after bit4", int'(count), 1);
    end
    checkOutput("ovl count", int'(count), 2);

    $display("[TB] async reset mid-pattern");
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("pre-reset state", int'(state), 2);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async rst state", int'(state), 0);
    checkOutput("async rst match", int'(match), 0);
    checkOutput("async rst count", int'(count), 0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] non-overlapping detection");
    overlap = 1'b0;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, stream7[6-i], 1'b0);
      checkOutput($sformatf("novl state[%0d]", i), int'(state), exp_rst_st[i]);
      checkOutput($sformatf("novl match[%0d]", i), int'(match), exp_rst_m[i]);
    end
    checkOutput("novl count", int'(count), 1);

    $display("[TB] enable gaps");
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("clr state", int'(state), 0);
    checkOutput("clr count", int'(count), 0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(gap_en[i][0], gap_din[i][0], 1'b0);
      checkOutput($sformatf("gap state[%0d]", i), int'(state), gap_st[i]);
      checkOutput($sformatf("gap match[%0d]", i), int'(match), gap_m[i]);
    end
    checkOutput("gap count", int'(count), 1);

    $display("[TB] clear collides with accepted bit");
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("pre-clr state", int'(state), 3);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("clr hit state", int'(state), 0);
    checkOutput("clr hit match", int'(match), 0);
    checkOutput("clr hit count", int'(count), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("post-clr match", int'(match), 0);
    checkOutput("post-clr count", int'(count), 0);

    $display("[TB] mode change mid-pattern");
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    overlap = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("mode chg state", int'(state), 1);
    checkOutput("mode chg match", int'(match), 1);
    checkOutput("mode chg count", int'(count), 1);

    $display("[TB] counter saturation");
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("sat clr count", int'(sat_count), 0);
    stream16 = 16'b1011011011011011;
    n_match = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, stream16[15-i], 1'b0);
      exp_m = (i >= 3 && (i - 3) % 3 == 0) ? 1 : 0;
      n_match += exp_m;
      checkOutput($sformatf("sat match[%0d]", i), int'(sat_match), exp_m);
      if (exp_m == 1) begin
        checkOutput($sformatf("sat count[%0d]", i), int'(sat_count), (n_match > 3) ? 3 : n_match);
        checkOutput($sformatf("wide count[%0d]", i), int'(count), n_match);
      end
    end
    checkOutput("sat final state", int'(sat_state), 1);
    checkOutput("sat matches seen", n_match, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
